note_sequencer: RTL and testbench
=================================

// Module: note_sequencer
// PURPOSE
//  Port-mapped melody player feeding the tone-generator peripheral's 8-bit note-code input.
//  The CPU writes (note, duration) pairs over the port bus into a FIFO.
//  The block presents each note on note_out for its duration in ms ticks.
//  A short rest (note_out=0) follows each note, then the next entry plays.
// PARAMETERS
//  CLK_HZ     100_000_000  system clock frequency
//  TICK_HZ    1000         duration unit rate (1 ms); CYC_PER_TICK = CLK_HZ/TICK_HZ, must be >=2
//  DEPTH      16           FIFO entries (power of 2)
//  GAP_TICKS  10           rest ticks inserted after every note (0 = no gap)
//  PORT_NOTE  8'h40        write: stage note code
//  PORT_DUR   8'h41        write: duration, pushes entry
//  PORT_CTRL  8'h42        write: control
// PORTS
//  clk         in   1  system clock, all logic on posedge
//  rst         in   1  synchronous, active-high reset
//  port_id     in   8  CPU port address
//  out_port    in   8  CPU write data
//  io_strb     in   1  one-cycle write strobe, qualifies port_id/out_port
//  note_out    out  8  note code to tone generator; 0 = silence, 1..36 = note
//  status      out  8  {overflow, full, empty, busy, enable, 3'b000} for CPU input mux
//  busy        out  1  high in LOAD/PLAY/GAP
// BEHAVIOUR
//  Reset: note_out=0, status=0 except empty=1, busy=0, enable=0, FIFO empty, staged note=0, state IDLE.
//  Writes are decoded only when io_strb=1 and port_id matches.
//  PORT_NOTE: stage note = out_port; values >36 stored as 0 (rest).
//  PORT_DUR, out_port!=0: push {staged_note, out_port}.
//    If full and no pop this cycle: push dropped, overflow set (sticky).
//    If full and pop in the same cycle: push accepted, count unchanged.
//  PORT_DUR, out_port==0: ignored, no push.
//  PORT_CTRL bit0: enable <= bit0 (level).
//  PORT_CTRL bit1=1: clear overflow.
//  PORT_CTRL bit2=1: flush. FIFO emptied, FSM -> IDLE, note_out=0 next cycle; an accompanying PORT_DUR push is impossible (different port).
//  FSM states:
//    IDLE: note_out=0. If enable && !empty -> pop -> LOAD.
//    LOAD: 1 cycle. Latch note/dur, clear tick and cycle counters -> PLAY.
//    PLAY: note_out=note for exactly dur*CYC_PER_TICK cycles.
//      Then -> GAP if GAP_TICKS>0, else behave as GAP exit.
//    GAP: note_out=0 for GAP_TICKS*CYC_PER_TICK cycles.
//      Exit: enable && !empty -> pop -> LOAD, else IDLE.
//  Latency: pop-to-note_out valid = 2 cycles (pop cycle, LOAD, PLAY first cycle).
//  Enable cleared mid-note: current PLAY+GAP complete, then IDLE; FIFO retained.
//  Tick counter width: $clog2(CYC_PER_TICK). Duration counter: 8 bits, counts 1..dur, no wrap.
//  busy = (state != IDLE). Status fields are registered, updated the cycle after the event.
// STRUCTURE
//  Package note_seq_pkg:
//    state_t enum {IDLE, LOAD, PLAY, GAP}
//    MAX_NOTE=36
//    entry_t struct {note[7:0], dur[7:0]}
//  Sub-module sync_fifo (#WIDTH=16, DEPTH): push/pop/full/empty/flush, same-cycle push+pop when full allowed.
//  Top: port decode, staged-note register, FSM, tick/duration counters.
// TESTING  (CLK_HZ=1000, TICK_HZ=100 -> 10 cycles/tick, DEPTH=4, GAP_TICKS=1)
//  1. Reset: rst=1 for 2 cycles -> note_out=0, status=8'h20, busy=0.
//  2. NOTE=5, DUR=3, CTRL=1 -> note_out=5 for exactly 30 cycles, then 0 for 10, then busy=0.
//  3. Push 5 entries while enable=0 -> first 4 accepted, overflow=1 (status=8'hC0).
//     Then CTRL=8'h02 -> overflow=0.
//  4. NOTE=40, DUR=2, play -> note_out stays 0 for 20 cycles (clamped rest), busy=1 throughout.
//  5. Mid-PLAY CTRL=8'h04 -> next cycle note_out=0, empty=1, busy=0.
//  6. Queue (7,1),(9,1) with enable=1, then CTRL=0 during first note
//     -> note 7 plays 10 cycles plus gap, note 9 does not start, FIFO holds 1.

Source files
------------

// File: rtl/note_seq_pkg.sv
// rtl/note_seq_pkg.sv - shared types and constants for the note sequencer
package note_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam logic [7:0] MAX_NOTE = 8'd36;

    typedef struct packed {
        logic [7:0] note;
        logic [7:0] dur;
    } entry_t;

    // Codes above the tone generator's range become rests.
    function automatic logic [7:0] clamp_note(input logic [7:0] code);
        return (code > MAX_NOTE) ? 8'd0 : code;
    endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// rtl/note_sequencer_if.sv - CPU port-write bus
interface note_sequencer_if;
    logic [7:0] port_id;
    logic [7:0] out_port;
    logic       io_strb;

    modport master (output port_id, output out_port, output io_strb);
    modport slave  (input  port_id, input  out_port, input  io_strb);
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through FIFO with flush and push-through-when-full
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign rdata_o = mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - port-mapped melody player driving a tone generator note code
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int         CLK_HZ    = 100_000_000,
    parameter int         TICK_HZ   = 1000,
    parameter int         DEPTH     = 16,
    parameter int         GAP_TICKS = 10,
    parameter logic [7:0] PORT_NOTE = 8'h40,
    parameter logic [7:0] PORT_DUR  = 8'h41,
    parameter logic [7:0] PORT_CTRL = 8'h42
) (
    input  logic                clk,
    input  logic                rst,
    note_sequencer_if.slave     bus,
    output logic [7:0]          note_out,
    output logic [7:0]          status,
    output logic                busy
);
    localparam int            CYC_PER_TICK = CLK_HZ / TICK_HZ;
    localparam int            TW           = $clog2(CYC_PER_TICK);
    localparam logic [TW-1:0] CYC_LAST     = TW'(CYC_PER_TICK - 1);
    localparam logic [7:0]    GAP8         = 8'(GAP_TICKS);

    state_t        state_q, state_d;
    logic [TW-1:0] cyc_q, cyc_d;
    logic [7:0]    tick_q, tick_d;
    logic [7:0]    note_q, note_d;
    logic [7:0]    dur_q, dur_d;
    logic [7:0]    staged_q;
    logic          enable_q, overflow_q;

    logic   wr_note, wr_dur, wr_ctrl, push, flush, pop, fetch;
    logic   fifo_full, fifo_empty;
    logic   cyc_last, seg_done;
    logic [7:0] tick_target;
    entry_t head, push_entry;

    assign wr_note = bus.io_strb && (bus.port_id == PORT_NOTE);
    assign wr_dur  = bus.io_strb && (bus.port_id == PORT_DUR);
    assign wr_ctrl = bus.io_strb && (bus.port_id == PORT_CTRL);
    assign push    = wr_dur && (bus.out_port != 8'd0);
    assign flush   = wr_ctrl && bus.out_port[2];
    assign push_entry = '{note: staged_q, dur: bus.out_port};

    sync_fifo #(.WIDTH(16), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .flush_i (flush),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            staged_q   <= 8'd0;
            enable_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_note) staged_q <= clamp_note(bus.out_port);
            if (wr_ctrl) enable_q <= bus.out_port[0];
            if (wr_ctrl && bus.out_port[1])      overflow_q <= 1'b0;
            else if (push && fifo_full && !pop)  overflow_q <= 1'b1;
        end
    end

    // One cycle/tick counter pair times both the note and the trailing gap.
    assign tick_target = (state_q == PLAY) ? dur_q : GAP8;
    assign cyc_last    = (cyc_q == CYC_LAST);
    assign seg_done    = cyc_last && (tick_q == tick_target);

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        tick_d  = tick_q;
        note_d  = note_q;
        dur_d   = dur_q;
        pop     = 1'b0;
        fetch   = 1'b0;
        unique case (state_q)
            IDLE: fetch = 1'b1;
            LOAD: begin
                cyc_d   = '0;
                tick_d  = 8'd1;
                state_d = PLAY;
            end
            PLAY, GAP: begin
                if (seg_done) begin
                    if (state_q == PLAY && GAP_TICKS > 0) begin
                        state_d = GAP;
                        cyc_d   = '0;
                        tick_d  = 8'd1;
                    end else begin
                        fetch = 1'b1;
                    end
                end else if (cyc_last) begin
                    cyc_d  = '0;
                    tick_d = tick_q + 8'd1;
                end else begin
                    cyc_d = cyc_q + TW'(1);
                end
            end
        endcase
        if (fetch) begin
            if (enable_q && !fifo_empty) begin
                pop     = 1'b1;
                note_d  = head.note;
                dur_d   = head.dur;
                state_d = LOAD;
            end else begin
                state_d = IDLE;
            end
        end
        if (flush) begin
            pop     = 1'b0;
            note_d  = note_q;
            dur_d   = dur_q;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            tick_q  <= 8'd0;
            note_q  <= 8'd0;
            dur_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            tick_q  <= tick_d;
            note_q  <= note_d;
            dur_q   <= dur_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign note_out = (state_q == PLAY) ? note_q : 8'd0;
    assign status   = {overflow_q, fifo_full, fifo_empty, busy, enable_q, 3'b000};

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - scoreboard bench for note_sequencer
module tb_note_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] note_out, status;
    logic       busy;

    note_sequencer_if bus();

    always #5 clk = ~clk;

    note_sequencer #(
        .CLK_HZ(1000), .TICK_HZ(100), .DEPTH(4), .GAP_TICKS(1)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .note_out(note_out), .status(status), .busy(busy)
    );

    typedef struct {
        logic [7:0] val;
        int         len;
    } seg_t;

    seg_t       exp_q[$];
    seg_t       exp_e;
    int         checks = 0;
    int         failures = 0;
    logic       in_seg = 1'b0;
    logic [7:0] seg_val = 8'd0;
    int         seg_len = 0;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endfunction

    task automatic exp_seg(input logic [7:0] v, input int l);
        seg_t s;
        s.val = v;
        s.len = l;
        exp_q.push_back(s);
    endtask

    task automatic emit_seg();
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL seg_unexpected actual=0x%0h/%0d expected=none", seg_val, seg_len);
        end else begin
            exp_e = exp_q.pop_front();
            chk("seg_note", int'(seg_val), int'(exp_e.val));
            chk("seg_len", seg_len, exp_e.len);
        end
    endtask

    // Run-length encode note_out while busy; each run is one scoreboard item.
    always @(negedge clk) begin
        if (!rst) begin
            if (busy) begin
                if (in_seg && note_out == seg_val) begin
                    seg_len++;
                end else begin
                    if (in_seg) emit_seg();
                    seg_val = note_out;
                    seg_len = 1;
                    in_seg  = 1'b1;
                end
            end else if (in_seg) begin
                emit_seg();
                in_seg = 1'b0;
            end
        end
    end

    task automatic wr(input logic [7:0] port, input logic [7:0] data);
        @(posedge clk);
        #1;
        bus.port_id  = port;
        bus.out_port = data;
        bus.io_strb  = 1'b1;
        @(posedge clk);
        #1;
        bus.io_strb  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!busy && n < 200) begin @(negedge clk); n++; end
        while (busy && n < 2000) begin @(negedge clk); n++; end
        chk(tag, int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        bus.port_id = 8'h00;
        bus.out_port = 8'h00;
        bus.io_strb = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_note", int'(note_out), 0);
        chk("rst_status", int'(status), 'h20);
        chk("rst_busy", int'(busy), 0);

        // single note with one gap tick
        exp_seg(8'd0, 1); exp_seg(8'd5, 30); exp_seg(8'd0, 10);
        wr(8'h40, 8'd5); wr(8'h41, 8'd3); wr(8'h42, 8'h01);
        wait_done("t2_done");
        chk("t2_status", int'(status), 'h28);

        // overflow with DEPTH=4, then clear, then flush
        wr(8'h42, 8'h00);
        for (int i = 1; i <= 5; i++) begin
            wr(8'h40, 8'(i));
            wr(8'h41, 8'd1);
        end
        chk("t3_overflow", int'(status), 'hC0);
        wr(8'h42, 8'h02);
        chk("t3_ovf_clr", int'(status), 'h40);
        wr(8'h42, 8'h04);
        chk("t3_flushed", int'(status), 'h20);

        // out-of-range note becomes a rest; busy never drops
        exp_seg(8'd0, 31);
        wr(8'h40, 8'd40); wr(8'h41, 8'd2); wr(8'h42, 8'h01);
        wait_done("t4_done");
        chk("t4_status", int'(status), 'h28);

        // flush mid-note; queued second entry must never play
        wr(8'h42, 8'h00);
        wr(8'h40, 8'd12); wr(8'h41, 8'd5);
        wr(8'h40, 8'd3);  wr(8'h41, 8'd1);
        exp_seg(8'd0, 1); exp_seg(8'd12, 7);
        wr(8'h42, 8'h01);
        n = 0;
        while (note_out != 8'd12 && n < 100) begin @(negedge clk); n++; end
        chk("t5_started", int'(note_out), 12);
        repeat (5) @(posedge clk);
        wr(8'h42, 8'h05);
        chk("t5_note", int'(note_out), 0);
        chk("t5_busy", int'(busy), 0);
        chk("t5_status", int'(status), 'h28);

        // disable during first note; second stays queued
        exp_seg(8'd0, 1); exp_seg(8'd7, 10); exp_seg(8'd0, 10);
        wr(8'h40, 8'd7); wr(8'h41, 8'd1);
        wr(8'h40, 8'd9); wr(8'h41, 8'd1);
        wr(8'h42, 8'h00);
        wait_done("t6_done");
        repeat (5) @(negedge clk);
        chk("t6_busy", int'(busy), 0);
        chk("t6_status", int'(status), 'h00);

        exp_seg(8'd0, 1); exp_seg(8'd9, 10); exp_seg(8'd0, 10);
        wr(8'h42, 8'h01);
        wait_done("t6_resume");
        chk("t6_resume_status", int'(status), 'h28);

        repeat (3) @(negedge clk);
        chk("sb_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
